// File: rtl/serial_ctrl_pkg.sv
// Shared definitions for the memory-mapped 8N1 UART: register map, status bit
// positions and the state encoding used by both serial FSMs.
package serial_ctrl_pkg;

    localparam logic [31:0] SERIAL_DATA_ADDR = 32'hbfd003f8;
    localparam logic [31:0] SERIAL_STAT_ADDR = 32'hbfd003fc;

    // Only this address bit separates DATA from STATUS.
    localparam int ADDR_SEL_BIT = 2;

    localparam int SER_TX_READY = 0;
    localparam int SER_RX_AVAIL = 1;
    localparam int SER_OVERRUN  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/serial_ctrl_fifo.sv
// Small synchronous FIFO holding received bytes; head is visible combinationally
// so a load can return it in the same cycle it pops.
module serial_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/serial_ctrl.sv
// Bus-side UART target: stores to DATA are serialised on uart_txd, bytes from
// uart_rxd are queued for DATA loads, STATUS reports tx/rx/overrun flags.
module serial_ctrl
    import serial_ctrl_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 434,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        uart_txd,
    input  logic        uart_rxd,
    output logic        int_o
);
    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic        r_ack;
    logic [31:0] r_data;
    logic        r_hold_full;
    logic [7:0]  r_hold;
    logic        r_overrun;

    logic        w_is_stat;
    logic        w_accept;
    logic        w_tx_store;
    logic        w_rx_load;
    logic        w_stat_load;
    logic [31:0] w_status;

    uart_state_t   r_tx_state;
    uart_state_t   w_tx_next;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_shift;
    logic          w_tx_cnt_done;
    logic          w_tx_take;
    logic          w_txd;

    logic          r_rx_sync1;
    logic          r_rx_sync2;
    logic          r_rx_prev;
    uart_state_t   r_rx_state;
    uart_state_t   w_rx_next;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic          w_rx_cnt_done;
    logic          w_rx_bit_tick;
    logic          w_rx_push;

    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [7:0]    w_fifo_head;

    logic          w_unused;
    assign w_unused = &{1'b0, addr_i[31:3], addr_i[1:0], data_i[31:8]};

    // ---------------- bus side ----------------
    assign w_is_stat   = addr_i[ADDR_SEL_BIT];
    assign w_accept    = ce_i && !r_ack && !(we_i && !w_is_stat && r_hold_full);
    assign w_tx_store  = w_accept && we_i && !w_is_stat;
    assign w_rx_load   = w_accept && !we_i && !w_is_stat;
    assign w_stat_load = w_accept && !we_i && w_is_stat;

    always_comb begin
        w_status               = '0;
        w_status[SER_TX_READY] = !r_hold_full;
        w_status[SER_RX_AVAIL] = !w_fifo_empty;
        w_status[SER_OVERRUN]  = r_overrun;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack       <= 1'b0;
            r_data      <= '0;
            r_hold_full <= 1'b0;
            r_hold      <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_ack <= w_accept;
            if (w_rx_load)        r_data <= w_fifo_empty ? 32'h0 : {24'h0, w_fifo_head};
            else if (w_stat_load) r_data <= w_status;
            else                  r_data <= '0;
            if (w_tx_store) begin
                r_hold      <= data_i[7:0];
                r_hold_full <= 1'b1;
            end else if (w_tx_take) begin
                r_hold_full <= 1'b0;
            end
            // A byte lost in the same cycle as a STATUS read must stay visible.
            if (w_rx_push && w_fifo_full) r_overrun <= 1'b1;
            else if (w_stat_load)         r_overrun <= 1'b0;
        end
    end

    assign ack_o  = r_ack;
    assign data_o = r_data;

    // ---------------- transmitter ----------------
    assign w_tx_cnt_done = (r_tx_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
        end else begin
            r_tx_state <= w_tx_next;
            if (w_tx_next != r_tx_state || r_tx_state == ST_IDLE || w_tx_cnt_done) r_tx_cnt <= '0;
            else                                                                  r_tx_cnt <= r_tx_cnt + CW'(1);
            if (r_tx_state == ST_DATA && w_tx_cnt_done) r_tx_bit <= r_tx_bit + 3'd1;
            if (w_tx_take) r_tx_shift <= r_hold;
        end
    end

    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_take = 1'b0;
        case (r_tx_state)
            ST_IDLE: begin
                if (r_hold_full) begin
                    w_tx_next = ST_START;
                    w_tx_take = 1'b1;
                end
            end
            ST_START: if (w_tx_cnt_done) w_tx_next = ST_DATA;
            ST_DATA:  if (w_tx_cnt_done && r_tx_bit == 3'd7) w_tx_next = ST_STOP;
            ST_STOP: begin
                // A waiting byte starts straight after the stop bit, no idle gap.
                if (w_tx_cnt_done) begin
                    if (r_hold_full) begin
                        w_tx_next = ST_START;
                        w_tx_take = 1'b1;
                    end else begin
                        w_tx_next = ST_IDLE;
                    end
                end
            end
            default: w_tx_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_txd = 1'b1;
        case (r_tx_state)
            ST_START: w_txd = 1'b0;
            ST_DATA:  w_txd = r_tx_shift[r_tx_bit];
            default:  w_txd = 1'b1;
        endcase
    end

    assign uart_txd = w_txd;

    // ---------------- receiver ----------------
    assign w_rx_cnt_done = (r_rx_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_sync1 <= 1'b1;
            r_rx_sync2 <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= ST_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_sync1 <= uart_rxd;
            r_rx_sync2 <= r_rx_sync1;
            r_rx_prev  <= r_rx_sync2;
            r_rx_state <= w_rx_next;
            if (w_rx_next != r_rx_state || r_rx_state == ST_IDLE || w_rx_cnt_done) r_rx_cnt <= '0;
            else                                                                  r_rx_cnt <= r_rx_cnt + CW'(1);
            if (w_rx_bit_tick) begin
                r_rx_shift <= {r_rx_sync2, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 3'd1;
            end
        end
    end

    // After the half-bit start check, every full-bit count lands mid-bit.
    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            ST_IDLE:  if (r_rx_prev && !r_rx_sync2) w_rx_next = ST_START;
            ST_START: if (r_rx_cnt == CNT_HALF) w_rx_next = r_rx_sync2 ? ST_IDLE : ST_DATA;
            ST_DATA:  if (w_rx_cnt_done && r_rx_bit == 3'd7) w_rx_next = ST_STOP;
            ST_STOP:  if (w_rx_cnt_done) w_rx_next = ST_IDLE;
            default:  w_rx_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rx_bit_tick = (r_rx_state == ST_DATA) && w_rx_cnt_done;
        w_rx_push     = (r_rx_state == ST_STOP) && w_rx_cnt_done && r_rx_sync2;
    end

    serial_fifo #(
        .WIDTH(8),
        .DEPTH(RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_rx_push),
        .i_din  (r_rx_shift),
        .i_pop  (w_rx_load),
        .o_full (w_fifo_full),
        .o_empty(w_fifo_empty),
        .o_head (w_fifo_head)
    );

    assign int_o = !w_fifo_empty;

endmodule
